// File: rtl/oflow_iou_scheduler.sv
// oflow_iou_scheduler
// Walks every (current-frame k, history h) bbox pair through the shared
// oflow_calc_iou unit. For each k it keeps the lowest 1-IoU cost (Q0.22).
// It then emits the best history index, the cost and a match flag.
//
// Ports
//   clk, reset_N          clock; synchronous active-high reset
//   start                 one-cycle frame start, accepted only when idle
//   num_k, num_hist       pair counts, clamped to MAX_K / MAX_HIST on start
//   cost_thresh           match threshold (cost <= thresh), latched on start
//   busy                  frame in progress (drops the cycle after done)
//   rd_en, rd_k_idx,
//   rd_hist_idx           bbox buffer read request
//   iou_start             one-cycle launch of oflow_calc_iou
//   iou_valid, iou_cost   IoU cost result
//   res_valid, res_*      per-k best match; res_* hold until the next result
//   done                  one-cycle end of frame (normal or aborted)
//   timeout_err           sticky watchdog flag, cleared by the next start
module oflow_iou_scheduler #(
  parameter int MAX_K    = 16,
  parameter int MAX_HIST = 16,
  parameter int IOU_LEN  = 22,
  parameter int TIMEOUT  = 64,
  localparam int K_W     = (MAX_K > 1) ? $clog2(MAX_K) : 1,
  localparam int H_W     = (MAX_HIST > 1) ? $clog2(MAX_HIST) : 1
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start,
  input  logic [K_W:0]       num_k,
  input  logic [H_W:0]       num_hist,
  input  logic [IOU_LEN-1:0] cost_thresh,
  output logic               busy,
  output logic               rd_en,
  output logic [K_W-1:0]     rd_k_idx,
  output logic [H_W-1:0]     rd_hist_idx,
  output logic               iou_start,
  input  logic               iou_valid,
  input  logic [IOU_LEN-1:0] iou_cost,
  output logic               res_valid,
  output logic [K_W-1:0]     res_k_idx,
  output logic [H_W-1:0]     res_hist_idx,
  output logic [IOU_LEN-1:0] res_cost,
  output logic               res_match,
  output logic               done,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_UPDATE, S_EMIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [K_W:0]       nk_q;
  logic [H_W:0]       nh_q;
  logic [IOU_LEN-1:0] thr_q, best_cost_q, cur_cost_q;
  logic [K_W-1:0]     k_q;
  logic [H_W-1:0]     h_q, best_h_q;
  logic [WD_W-1:0]    wd_q;
  logic               busy_q, rd_en_q, iou_start_q, done_q, tmo_q;
  logic               res_valid_q, res_match_q;
  logic [K_W-1:0]     res_k_q;
  logic [H_W-1:0]     res_h_q;
  logic [IOU_LEN-1:0] res_cost_q;

  logic [K_W:0] nk_in;
  logic [H_W:0] nh_in;
  logic         start_ok, last_h, last_k, wd_exp;

  // Oversized counts saturate at the buffer depth.
  assign nk_in    = (num_k > (K_W+1)'(MAX_K)) ? (K_W+1)'(MAX_K) : num_k;
  assign nh_in    = (num_hist > (H_W+1)'(MAX_HIST)) ? (H_W+1)'(MAX_HIST) : num_hist;
  // busy stays high through the done cycle, so a start there is ignored.
  assign start_ok = start && !busy_q;
  assign last_h   = ((H_W+1)'(h_q) + (H_W+1)'(1)) == nh_q;
  assign last_k   = ((K_W+1)'(k_q) + (K_W+1)'(1)) == nk_q;
  assign wd_exp   = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = (nk_in == '0) ? S_DONE :
                                        (nh_in == '0) ? S_EMIT : S_FETCH;
      S_FETCH:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (iou_valid)   state_d = S_UPDATE;
                else if (wd_exp) state_d = S_DONE;
      S_UPDATE: state_d = last_h ? S_EMIT : S_FETCH;
      S_EMIT:   state_d = last_k ? S_DONE : ((nh_q == '0) ? S_EMIT : S_FETCH);
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q     <= S_IDLE;
      nk_q        <= '0;
      nh_q        <= '0;
      thr_q       <= '0;
      k_q         <= '0;
      h_q         <= '0;
      best_cost_q <= '0;
      best_h_q    <= '0;
      cur_cost_q  <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      iou_start_q <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_k_q     <= '0;
      res_h_q     <= '0;
      res_cost_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= (state_d == S_FETCH);
      iou_start_q <= (state_d == S_LAUNCH);
      busy_q      <= (state_d != S_IDLE) || (state_q == S_DONE);
      done_q      <= (state_q == S_DONE);
      res_valid_q <= (state_q == S_EMIT);
      case (state_q)
        S_IDLE: if (start_ok) begin
          nk_q        <= nk_in;
          nh_q        <= nh_in;
          thr_q       <= cost_thresh;
          k_q         <= '0;
          h_q         <= '0;
          best_cost_q <= '1;
          best_h_q    <= '0;
          tmo_q       <= 1'b0;
        end
        S_LAUNCH: wd_q <= '0;
        S_WAIT: begin
          if (iou_valid)   cur_cost_q <= iou_cost;
          else if (wd_exp) tmo_q      <= 1'b1;
          else             wd_q       <= wd_q + 1'b1;
        end
        S_UPDATE: begin
          // Strict less-than keeps the lowest h on ties.
          if (cur_cost_q < best_cost_q) begin
            best_cost_q <= cur_cost_q;
            best_h_q    <= h_q;
          end
          if (!last_h) h_q <= h_q + 1'b1;
        end
        S_EMIT: begin
          res_k_q     <= k_q;
          res_h_q     <= best_h_q;
          res_cost_q  <= best_cost_q;
          res_match_q <= (nh_q != '0) && (best_cost_q <= thr_q);
          best_cost_q <= '1;
          best_h_q    <= '0;
          h_q         <= '0;
          if (!last_k) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = busy_q;
  assign rd_en        = rd_en_q;
  assign rd_k_idx     = k_q;
  assign rd_hist_idx  = h_q;
  assign iou_start    = iou_start_q;
  assign res_valid    = res_valid_q;
  assign res_k_idx    = res_k_q;
  assign res_hist_idx = res_h_q;
  assign res_cost     = res_cost_q;
  assign res_match    = res_match_q;
  assign done         = done_q;
  assign timeout_err  = tmo_q;

endmodule
